// File: rtl/uart_packet_bridge_pkg.sv
// -----------------------------------------------------------------------------
// uart_packet_bridge_pkg
//   Shared defaults and encodings for the UART packet bridge slice.
//   No ports; imported by uart_word_fifo and uart_packet_bridge.
// -----------------------------------------------------------------------------
package uart_packet_bridge_pkg;

   localparam int UART_PKT_BYTES_PER_WORD = 4;
   localparam int UART_PKT_BW_BPW         = 2;
   localparam int UART_PKT_DEPTH          = 8;
   localparam int UART_PKT_BW_DEPTH       = 3;
   localparam int UART_PKT_TIMEOUT        = 1024;

   // Unpacker state encodings
   localparam logic [0:0] TX_IDLE = 1'b0;
   localparam logic [0:0] TX_SEND = 1'b1;

   typedef struct packed {
      logic timeout_drop;
      logic overflow;
   } err_flags_t;

endpackage

// File: rtl/uart_word_fifo.sv
// -----------------------------------------------------------------------------
// uart_word_fifo
//   Synchronous show-ahead word FIFO. rd_data presents the head entry while
//   empty is low and reads as zero while empty.
//   Ports:
//     clk_sys, rst_b      clock, asynchronous active-low reset
//     push, wr_data       write one entry (ignored when full unless popping)
//     pop                 remove head entry (ignored when empty)
//     rd_data             head entry
//     full, empty, count  occupancy status (count = 0..DEPTH)
// -----------------------------------------------------------------------------
module uart_word_fifo
   import uart_packet_bridge_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = UART_PKT_DEPTH,
   parameter int BW_DEPTH = UART_PKT_BW_DEPTH
) (
   input  logic                clk_sys,
   input  logic                rst_b,
   input  logic                push,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic                pop,
   output logic [DATA_W-1:0]   rd_data,
   output logic                full,
   output logic                empty,
   output logic [BW_DEPTH:0]   count
);

   localparam logic [BW_DEPTH:0] FULL_CNT = (BW_DEPTH+1)'(DEPTH);

   logic [DATA_W-1:0]   mem [DEPTH];
   logic [BW_DEPTH-1:0] wr_ptr;
   logic [BW_DEPTH-1:0] rd_ptr;
   logic                do_push;
   logic                do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   // A pop frees the slot in the same edge, so push is allowed when full.
   assign do_push = push & (~full | do_pop);
   assign rd_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk_sys or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + BW_DEPTH'(1);
         if (do_pop)  rd_ptr <= rd_ptr + BW_DEPTH'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (BW_DEPTH+1)'(1);
            2'b01:   count <= count - (BW_DEPTH+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/uart_packet_bridge.sv
// -----------------------------------------------------------------------------
// uart_packet_bridge
//   Byte <-> word bridge between the JTAG-UART byte driver and the comm
//   controller. RX bytes are packed little-endian into words and queued;
//   TX words are queued and unpacked to bytes. A stale partial RX word is
//   dropped after TIMEOUT_CYC idle cycles. Sticky {timeout_drop, overflow}.
//   Ports:
//     clock_i, resetn_i               clock, asynchronous active-low reset
//     rx_valid_i/rx_byte_i/rx_ready_o byte input handshake
//     tx_valid_o/tx_byte_o/tx_ready_i byte output handshake
//     rx_read_i/rx_data_o/rx_empty_o/rx_count_o  RX word queue (show-ahead)
//     tx_write_i/tx_data_i/tx_full_o  TX word queue
//     clear_i                         clears sticky flags and partial RX word
//     err_o                           sticky {timeout_drop, overflow}
//
//   Unpacker FSM
//     state   | meaning
//     TX_IDLE | no word held; loads and pops TX queue head when available
//     TX_SEND | presenting byte tx_idx of tx_word; last byte chains next word
// -----------------------------------------------------------------------------
module uart_packet_bridge
   import uart_packet_bridge_pkg::*;
#(
   parameter int DATA_W         = 8 * UART_PKT_BYTES_PER_WORD,
   parameter int BYTES_PER_WORD = UART_PKT_BYTES_PER_WORD,
   parameter int BW_BPW         = UART_PKT_BW_BPW,
   parameter int DEPTH          = UART_PKT_DEPTH,
   parameter int BW_DEPTH       = UART_PKT_BW_DEPTH,
   parameter int TIMEOUT_CYC    = UART_PKT_TIMEOUT
) (
   input  logic                clock_i,
   input  logic                resetn_i,
   input  logic                rx_valid_i,
   input  logic [7:0]          rx_byte_i,
   output logic                rx_ready_o,
   output logic                tx_valid_o,
   output logic [7:0]          tx_byte_o,
   input  logic                tx_ready_i,
   input  logic                rx_read_i,
   output logic [DATA_W-1:0]   rx_data_o,
   output logic                rx_empty_o,
   output logic [BW_DEPTH:0]   rx_count_o,
   input  logic                tx_write_i,
   input  logic [DATA_W-1:0]   tx_data_i,
   output logic                tx_full_o,
   input  logic                clear_i,
   output logic [1:0]          err_o
);

   localparam logic [BW_BPW-1:0] LAST_LANE = BW_BPW'(BYTES_PER_WORD - 1);

   // ---------------------------------------------------------------- RX side
   logic                rx_full;
   logic                rx_accept;
   logic                rx_take;
   logic                rx_push;
   logic                timeout_hit;
   logic [BW_BPW-1:0]   pk_cnt;
   logic [DATA_W-1:0]   pk_word;
   logic [DATA_W-1:0]   pk_word_next;

   // Only the last lane needs queue space; earlier lanes land in pk_word.
   assign rx_ready_o = ~(rx_full & (pk_cnt == LAST_LANE));
   assign rx_accept  = rx_valid_i & rx_ready_o;
   // clear_i wins over a byte accepted in the same cycle.
   assign rx_take    = rx_accept & ~clear_i;
   assign rx_push    = rx_take & (pk_cnt == LAST_LANE);

   always_comb begin
      pk_word_next = pk_word;
      pk_word_next[{pk_cnt, 3'b000} +: 8] = rx_byte_i;
   end

   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         pk_cnt  <= '0;
         pk_word <= '0;
      end else if (clear_i) begin
         pk_cnt  <= '0;
      end else if (rx_take) begin
         pk_word <= pk_word_next;
         pk_cnt  <= (pk_cnt == LAST_LANE) ? '0 : pk_cnt + BW_BPW'(1);
      end else if (timeout_hit) begin
         pk_cnt  <= '0;
      end
   end

   // Idle timer: loaded on each accepted byte, counts down while a partial
   // word is held; reaching zero with no new byte drops the partial word.
   generate
      if (TIMEOUT_CYC > 0) begin : g_timer
         localparam int TM_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
         localparam logic [TM_W-1:0] TM_LOAD = TM_W'(TIMEOUT_CYC - 1);

         logic [TM_W-1:0] idle_tmr;

         always_ff @(posedge clock_i or negedge resetn_i) begin
            if (!resetn_i) begin
               idle_tmr <= '0;
            end else if (clear_i) begin
               idle_tmr <= '0;
            end else if (rx_take) begin
               idle_tmr <= TM_LOAD;
            end else if ((pk_cnt != '0) && (idle_tmr != '0)) begin
               idle_tmr <= idle_tmr - TM_W'(1);
            end
         end

         assign timeout_hit = (pk_cnt != '0) & ~rx_take & ~clear_i & (idle_tmr == '0);
      end else begin : g_no_timer
         assign timeout_hit = 1'b0;
      end
   endgenerate

   uart_word_fifo #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .BW_DEPTH (BW_DEPTH)
   ) u_rx_fifo (
      .clk_sys  (clock_i),
      .rst_b    (resetn_i),
      .push     (rx_push),
      .wr_data  (pk_word_next),
      .pop      (rx_read_i),
      .rd_data  (rx_data_o),
      .full     (rx_full),
      .empty    (rx_empty_o),
      .count    (rx_count_o)
   );

   // ---------------------------------------------------------------- TX side
   logic                tx_empty;
   logic                tx_pop;
   logic                tx_fire;
   logic                tx_last;
   logic                tx_overflow;
   logic [DATA_W-1:0]   tx_head;
   logic [BW_DEPTH:0]   tx_count_unused;
   logic [0:0]          tx_state;
   logic [BW_BPW-1:0]   tx_idx;
   logic [DATA_W-1:0]   tx_word;

   // tx_full_o is registered, so a write racing an unpacker pop still drops.
   assign tx_overflow = tx_write_i & tx_full_o;

   uart_word_fifo #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .BW_DEPTH (BW_DEPTH)
   ) u_tx_fifo (
      .clk_sys  (clock_i),
      .rst_b    (resetn_i),
      .push     (tx_write_i & ~tx_full_o),
      .wr_data  (tx_data_i),
      .pop      (tx_pop),
      .rd_data  (tx_head),
      .full     (tx_full_o),
      .empty    (tx_empty),
      .count    (tx_count_unused)
   );

   assign tx_valid_o = (tx_state == TX_SEND);
   assign tx_byte_o  = tx_valid_o ? tx_word[{tx_idx, 3'b000} +: 8] : 8'h00;
   assign tx_fire    = tx_valid_o & tx_ready_i;
   assign tx_last    = (tx_idx == LAST_LANE);
   assign tx_pop     = ~tx_empty & ((tx_state == TX_IDLE) | (tx_fire & tx_last));

   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         tx_state <= TX_IDLE;
         tx_idx   <= '0;
         tx_word  <= '0;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               if (!tx_empty) begin
                  tx_word  <= tx_head;
                  tx_idx   <= '0;
                  tx_state <= TX_SEND;
               end
            end
            TX_SEND: begin
               if (tx_fire) begin
                  if (tx_last) begin
                     tx_idx <= '0;
                     if (!tx_empty) begin
                        tx_word <= tx_head;
                     end else begin
                        tx_state <= TX_IDLE;
                     end
                  end else begin
                     tx_idx <= tx_idx + BW_BPW'(1);
                  end
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------- sticky flags
   err_flags_t err_q;

   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         err_q <= '0;
      end else if (clear_i) begin
         err_q <= '0;
      end else begin
         if (timeout_hit) err_q.timeout_drop <= 1'b1;
         if (tx_overflow) err_q.overflow     <= 1'b1;
      end
   end

   assign err_o = err_q;

endmodule

// File: tb/tb_uart_packet_bridge.sv
module tb_uart_packet_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx_valid, rx_ready, tx_valid, tx_ready, rx_read, rx_empty;
   logic        tx_write, tx_full, clear;
   logic [7:0]  rx_byte, tx_byte;
   logic [31:0] rx_data, tx_data;
   logic [3:0]  rx_count;
   logic [1:0]  err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_packet_bridge #(.TIMEOUT_CYC(16)) dut (
      .clock_i    (clk),
      .resetn_i   (rst_n),
      .rx_valid_i (rx_valid),
      .rx_byte_i  (rx_byte),
      .rx_ready_o (rx_ready),
      .tx_valid_o (tx_valid),
      .tx_byte_o  (tx_byte),
      .tx_ready_i (tx_ready),
      .rx_read_i  (rx_read),
      .rx_data_o  (rx_data),
      .rx_empty_o (rx_empty),
      .rx_count_o (rx_count),
      .tx_write_i (tx_write),
      .tx_data_i  (tx_data),
      .tx_full_o  (tx_full),
      .clear_i    (clear),
      .err_o      (err)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      rx_valid = 1'b1;
      rx_byte  = b;
      n = 0;
      while (!rx_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) begin
         checks++; errors++;
         $display("FAIL send_byte_timeout: rx_ready stayed 0 for byte %h", b);
      end
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic pop_rx();
      rx_read = 1'b1;
      tick();
      rx_read = 1'b0;
   endtask

   task automatic write_tx(input logic [31:0] w);
      tx_write = 1'b1;
      tx_data  = w;
      tick();
      tx_write = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL %s_rx_empty: got %b want 1", tag, rx_empty); end
      checks++; if (rx_count !== 4'd0) begin errors++; $display("FAIL %s_rx_count: got %0d want 0", tag, rx_count); end
      checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL %s_tx_full: got %b want 0", tag, tx_full); end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL %s_tx_valid: got %b want 0", tag, tx_valid); end
      checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL %s_tx_byte: got %h want 00", tag, tx_byte); end
      checks++; if (rx_data !== 32'h0) begin errors++; $display("FAIL %s_rx_data: got %h want 0", tag, rx_data); end
      checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL %s_rx_ready: got %b want 1", tag, rx_ready); end
      checks++; if (err !== 2'b00) begin errors++; $display("FAIL %s_err: got %b want 00", tag, err); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rx_valid = 0; rx_byte = 0; tx_ready = 0; rx_read = 0;
      tx_write = 0; tx_data = 0; clear = 0;
      repeat (3) tick();
      check_reset_values("reset");
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_rx_pack();
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL pack_partial_empty: got %b want 1", rx_empty); end
      send_byte(8'h44);
      checks++; if (rx_data !== 32'h44332211) begin errors++; $display("FAIL pack_word: got %h want 44332211", rx_data); end
      checks++; if (rx_count !== 4'd1) begin errors++; $display("FAIL pack_count: got %0d want 1", rx_count); end
      pop_rx();
      checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL pack_pop_empty: got %b want 1", rx_empty); end
   endtask

   task automatic test_rx_full();
      logic [31:0] exp_w [8];
      for (int k = 0; k < 8; k++) begin
         for (int j = 0; j < 4; j++) send_byte(8'(16*k + j));
         exp_w[k] = {8'(16*k+3), 8'(16*k+2), 8'(16*k+1), 8'(16*k)};
      end
      checks++; if (rx_count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d want 8", rx_count); end
      checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL full_ready_cnt0: got %b want 1", rx_ready); end
      send_byte(8'hA0); send_byte(8'hA1); send_byte(8'hA2);
      checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL full_ready_cnt3: got %b want 0", rx_ready); end
      checks++; if (rx_data !== 32'h03020100) begin errors++; $display("FAIL full_head0: got %h want 03020100", rx_data); end
      pop_rx();
      checks++; if (rx_count !== 4'd7) begin errors++; $display("FAIL full_after_read: got %0d want 7", rx_count); end
      send_byte(8'hA3);
      checks++; if (rx_count !== 4'd8) begin errors++; $display("FAIL full_ninth_count: got %0d want 8", rx_count); end
      for (int i = 0; i < 8; i++) begin
         logic [31:0] w;
         w = (i < 7) ? exp_w[i+1] : 32'hA3A2A1A0;
         checks++; if (rx_data !== w) begin errors++; $display("FAIL full_drain_%0d: got %h want %h", i, rx_data, w); end
         pop_rx();
      end
      pop_rx();
      checks++; if (rx_count !== 4'd0 || rx_empty !== 1'b1) begin errors++; $display("FAIL full_read_empty: count %0d empty %b want 0/1", rx_count, rx_empty); end
   endtask

   task automatic test_timeout();
      send_byte(8'hAA); send_byte(8'hBB);
      repeat (15) tick();
      checks++; if (err !== 2'b00) begin errors++; $display("FAIL timeout_early: got %b want 00", err); end
      tick();
      checks++; if (err !== 2'b10) begin errors++; $display("FAIL timeout_err: got %b want 10", err); end
      checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL timeout_no_push: got %b want 1", rx_empty); end
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      checks++; if (rx_data !== 32'h04030201) begin errors++; $display("FAIL timeout_next_word: got %h want 04030201", rx_data); end
      clear = 1'b1; tick(); clear = 1'b0;
      checks++; if (err !== 2'b00) begin errors++; $display("FAIL clear_err: got %b want 00", err); end
      // byte coinciding with clear is discarded
      rx_valid = 1'b1; rx_byte = 8'hEE; clear = 1'b1; tick();
      rx_valid = 1'b0; clear = 1'b0;
      send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
      checks++; if (rx_count !== 4'd2) begin errors++; $display("FAIL clear_count: got %0d want 2", rx_count); end
      pop_rx();
      checks++; if (rx_data !== 32'h08070605) begin errors++; $display("FAIL clear_byte_dropped: got %h want 08070605", rx_data); end
      pop_rx();
   endtask

   task automatic test_tx_overflow();
      int n;
      tx_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         write_tx({8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
         if (k == 7) begin
            checks++; if (tx_full !== 1'b0) begin errors++; $display("FAIL ovf_not_full: got %b want 0", tx_full); end
         end
         if (k == 8) begin
            checks++; if (tx_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", tx_full); end
            checks++; if (err !== 2'b00) begin errors++; $display("FAIL ovf_no_err_yet: got %b want 00", err); end
         end
      end
      checks++; if (err !== 2'b01) begin errors++; $display("FAIL ovf_err: got %b want 01", err); end
      checks++; if (tx_valid !== 1'b1 || tx_byte !== 8'h00) begin errors++; $display("FAIL ovf_hold: valid %b byte %h want 1/00", tx_valid, tx_byte); end
      tick();
      checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL ovf_hold_stable: got %h want 00", tx_byte); end
      tx_ready = 1'b1;
      for (int i = 0; i < 36; i++) begin
         n = 0;
         while (!tx_valid && n < 20) begin tick(); n++; end
         checks++; if (tx_byte !== 8'(i) || n >= 20) begin errors++; $display("FAIL ovf_stream_%0d: got %h want %h", i, tx_byte, 8'(i)); end
         tick();
      end
      repeat (5) tick();
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL ovf_tenth_absent: tx_valid %b want 0 (byte %h)", tx_valid, tx_byte); end
      tx_ready = 1'b0;
      clear = 1'b1; tick(); clear = 1'b0;
   endtask

   task automatic test_tx_random();
      logic [7:0]  exp_b [8];
      logic [31:0] pat;
      logic [7:0]  held;
      logic        hold_pending;
      int got, cyc;
      exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h04, 8'h03, 8'h02, 8'h01};
      pat = 32'b1011_0010_1101_0110_0111_0100_1011_1001;
      tx_ready = 1'b0;
      write_tx(32'hDEADBEEF);
      write_tx(32'h01020304);
      got = 0; cyc = 0; hold_pending = 1'b0; held = 8'h00;
      while (got < 8 && cyc < 200) begin
         tx_ready = pat[cyc % 32];
         if (hold_pending && tx_valid) begin
            checks++; if (tx_byte !== held) begin errors++; $display("FAIL rand_stable: got %h want %h", tx_byte, held); end
         end
         hold_pending = tx_valid && !tx_ready;
         held = tx_byte;
         if (tx_valid && tx_ready) begin
            checks++; if (tx_byte !== exp_b[got]) begin errors++; $display("FAIL rand_byte_%0d: got %h want %h", got, tx_byte, exp_b[got]); end
            got++;
         end
         tick();
         cyc++;
      end
      checks++; if (got != 8) begin errors++; $display("FAIL rand_count: got %0d bytes want 8", got); end
      tx_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_b [8];
      int n;
      exp_b = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h04, 8'h03, 8'h02, 8'h01};
      tx_ready = 1'b1;
      write_tx(32'hDEADBEEF);
      write_tx(32'h01020304);
      n = 0;
      while (!tx_valid && n < 20) begin tick(); n++; end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (tx_valid !== 1'b1 || tx_byte !== exp_b[i]) begin
            errors++; $display("FAIL b2b_byte_%0d: valid %b byte %h want 1/%h", i, tx_valid, tx_byte, exp_b[i]);
         end
         tick();
      end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_idle: got %b want 0", tx_valid); end
      tx_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      send_byte(8'h55); send_byte(8'h66);
      tx_ready = 1'b1;
      write_tx(32'hCAFEF00D);
      tick();
      tick();
      tx_ready = 1'b0;
      checks++; if (tx_valid !== 1'b1 || tx_byte !== 8'hF0) begin errors++; $display("FAIL mid_tx_byte1: valid %b byte %h want 1/F0", tx_valid, tx_byte); end
      rst_n = 1'b0;
      #1;
      check_reset_values("mid_reset");
      tick(); tick();
      rst_n = 1'b1;
      tx_ready = 1'b1;
      repeat (5) begin
         tick();
         checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_no_tx: got %b want 0", tx_valid); end
      end
      tx_ready = 1'b0;
      send_byte(8'h71); send_byte(8'h72); send_byte(8'h73); send_byte(8'h74);
      checks++; if (rx_data !== 32'h74737271 || rx_count !== 4'd1) begin errors++; $display("FAIL mid_clean_word: got %h count %0d want 74737271/1", rx_data, rx_count); end
   endtask

   initial begin
      test_reset();
      test_rx_pack();
      test_rx_full();
      test_timeout();
      test_tx_overflow();
      test_tx_random();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
